fft_frame_sched: RTL and testbench

- Frame scheduler and controller for the radix-2^2 SDF FFT pipeline.
- Accepts a sample stream, drives the pipeline enable, the stage-0 counter and the input data.
- Inserts zero frames to flush the last real frame out when input stops.
- Tags pipeline outputs so only real-frame results reach the downstream consumer, with bit-reversed bin index and frame markers.

---
 rtl/fft_frame_sched.sv | 172 +++++++++++++++++
 tb/tb_fft_frame_sched.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_sched.sv
// fft_frame_sched: frame scheduler for a radix-2^2 SDF FFT pipeline.
// Feeds samples, zero-fills to drain the tail frame, tags real outputs.
module fft_frame_sched #(
  parameter int WIDTH = 24,
  parameter int N     = 1024,
  parameter int LAT   = 1024,
  parameter int TAGS  = 4,
  localparam int LW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             s_last,
  input  logic [WIDTH-1:0] s_re,
  input  logic [WIDTH-1:0] s_im,
  output logic             fft_en,
  output logic [LW-1:0]    fft_ctr,
  output logic [WIDTH-1:0] fft_re,
  output logic [WIDTH-1:0] fft_im,
  input  logic [WIDTH-1:0] p_re,
  input  logic [WIDTH-1:0] p_im,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_re,
  output logic [WIDTH-1:0] m_im,
  output logic [LW-1:0]    m_idx,
  output logic             m_first,
  output logic             m_last,
  output logic             busy,
  output logic             err_frame
);
  localparam int FW = $clog2(LAT + 1);
  localparam int CW = $clog2(TAGS + 1);
  localparam logic [LW-1:0] CMAX = LW'(N - 1);
  localparam logic [LW-1:0] C1   = LW'(1);
  localparam logic [FW-1:0] FMAX = FW'(LAT);
  localparam logic [FW-1:0] F1   = FW'(1);
  localparam logic [CW-1:0] T1   = CW'(1);
  localparam logic [CW-1:0] TFUL = CW'(TAGS);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state;
  logic [LW-1:0]   in_cnt;
  logic [LW-1:0]   out_cnt;
  logic [FW-1:0]   fill;
  logic [TAGS-1:0] tq;
  logic [TAGS-1:0] tq_n;
  logic [CW-1:0]   tc;
  logic [CW-1:0]   tc_n;
  logic [CW-1:0]   pend;
  logic            cur_tag;

  logic flushing;
  logic acc;
  logic full;
  logic out_en;
  logic push;
  logic pop;
  logic tag_now;
  logic emit;
  logic done;
  logic has_pend;
  logic wrap;
  logic to_idle;

  function automatic logic [LW-1:0] bitrev(input logic [LW-1:0] v);
    logic [LW-1:0] r;
    for (int i = 0; i < LW; i++) r[i] = v[LW-1-i];
    return r;
  endfunction

  assign flushing = state == FLUSH;
  assign s_ready  = !flushing;
  assign acc      = s_valid && s_ready;
  assign fft_en   = acc || flushing;
  assign fft_re   = flushing ? '0 : s_re;
  assign fft_im   = flushing ? '0 : s_im;
  assign fft_ctr  = in_cnt;
  assign busy     = state != IDLE;

  assign full    = fill == FMAX;
  assign out_en  = fft_en && full;
  assign push    = fft_en && in_cnt == '0;
  assign pop     = out_en && out_cnt == '0;
  assign tag_now = pop ? tq[0] : cur_tag;
  assign emit    = out_en && tag_now;
  assign done    = emit && out_cnt == CMAX;
  assign wrap    = fft_en && in_cnt == CMAX;
  assign to_idle = flushing && wrap && !has_pend;

  // a frame finishing this cycle no longer counts as outstanding
  assign has_pend = done ? (pend > T1) : (pend != '0);

  always_comb begin
    tq_n = tq;
    tc_n = tc;
    if (pop) begin
      tq_n = tq >> 1;
      tc_n = tc - T1;
    end
    if (push) begin
      for (int i = 0; i < TAGS; i++)
        if (i == int'(tc_n)) tq_n[i] = !flushing;
      tc_n = tc_n + T1;
    end
  end

  a_tag_ovf: assert property (
    @(posedge clk) disable iff (arst)
    !(push && !pop && tc == TFUL));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state     <= IDLE;
      in_cnt    <= '0;
      out_cnt   <= '0;
      fill      <= '0;
      tq        <= '0;
      tc        <= '0;
      pend      <= '0;
      cur_tag   <= 1'b0;
      m_valid   <= 1'b0;
      m_re      <= '0;
      m_im      <= '0;
      m_idx     <= '0;
      m_first   <= 1'b0;
      m_last    <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      unique case (state)
        IDLE:
          if (s_valid) state <= RUN;
        RUN:
          if (in_cnt == '0 && !s_valid && has_pend)
            state <= FLUSH;
        FLUSH:
          if (wrap) begin
            if (!has_pend) state <= IDLE;
            else if (s_valid) state <= RUN;
          end
        default: state <= IDLE;
      endcase
      if (fft_en) in_cnt <= in_cnt + C1;
      if (fft_en && !full) fill <= fill + F1;
      if (out_en) out_cnt <= out_cnt + C1;
      if (pop) cur_tag <= tq[0];
      tq   <= tq_n;
      tc   <= tc_n;
      pend <= pend + ((push && !flushing) ? T1 : '0)
                   - (done ? T1 : '0);
      m_valid <= emit;
      m_first <= emit && out_cnt == '0;
      m_last  <= done;
      if (emit) begin
        m_re  <= p_re;
        m_im  <= p_im;
        m_idx <= bitrev(out_cnt);
      end
      err_frame <= acc && (s_last != (in_cnt == CMAX));
      // leftover zero tags and pipeline state are stale once idle
      if (to_idle) begin
        fill    <= '0;
        out_cnt <= '0;
        tq      <= '0;
        tc      <= '0;
        pend    <= '0;
        cur_tag <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fft_frame_sched.sv
// tb_fft_frame_sched: random-stimulus bench for fft_frame_sched.
// An ideal LAT-deep delay line stands in for the FFT pipeline.
module tb_fft_frame_sched;
  localparam int W   = 24;
  localparam int N   = 256;
  localparam int LAT = 256;
  localparam int LW  = $clog2(N);

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [LW-1:0] idx;
    logic          fst;
    logic          lst;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [W-1:0]  s_re;
  logic [W-1:0]  s_im;
  logic          fft_en;
  logic [LW-1:0] fft_ctr;
  logic [W-1:0]  fft_re;
  logic [W-1:0]  fft_im;
  logic [W-1:0]  p_re;
  logic [W-1:0]  p_im;
  logic          m_valid;
  logic [W-1:0]  m_re;
  logic [W-1:0]  m_im;
  logic [LW-1:0] m_idx;
  logic          m_first;
  logic          m_last;
  logic          busy;
  logic          err_frame;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_err   = 0;
  int pos     = 0;
  exp_t exq[$];
  logic [LW-1:0] idx_log[$];

  logic [2*W-1:0] pmem [LAT];
  int             wp = 0;
  logic           en_s = 1'b0;
  logic [2*W-1:0] d_s = '0;

  fft_frame_sched #(.WIDTH(W), .N(N), .LAT(LAT), .TAGS(4)) dut (
    .clk(clk), .arst(arst),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_re(s_re), .s_im(s_im),
    .fft_en(fft_en), .fft_ctr(fft_ctr),
    .fft_re(fft_re), .fft_im(fft_im),
    .p_re(p_re), .p_im(p_im),
    .m_valid(m_valid), .m_re(m_re), .m_im(m_im),
    .m_idx(m_idx), .m_first(m_first), .m_last(m_last),
    .busy(busy), .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #2;
    en_s <= fft_en;
    d_s  <= {fft_re, fft_im};
  end

  always @(posedge clk) begin
    if (en_s) begin
      pmem[wp] <= d_s;
      wp <= (wp + 1) % LAT;
    end
  end

  assign p_re = pmem[wp][2*W-1:W];
  assign p_im = pmem[wp][W-1:0];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [LW-1:0] brev(input int v);
    logic [LW-1:0] r;
    for (int b = 0; b < LW; b++) r[LW-1-b] = v[b];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!arst) begin
      if (m_valid) begin
        n_out++;
        idx_log.push_back(m_idx);
        if (exq.size() == 0) begin
          check("m_extra", 64'(1), 64'(0));
        end else begin
          exp_t e;
          e = exq.pop_front();
          check("m_out", 64'({m_re, m_im, m_idx, m_first, m_last}),
                64'(e));
        end
      end else begin
        check("m_fl_idle", 64'({m_first, m_last}), 64'(0));
      end
      if (err_frame) n_err++;
    end
  end

  task automatic send(input int n, input int gap_pct, input int bad_at,
                      output int waits);
    int wt;
    waits = 0;
    for (int i = 0; i < n; i++) begin
      while (pos != 0 && int'($urandom_range(99)) < gap_pct) begin
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        #1;
        check("gap_en", 64'(fft_en), 64'(0));
        check("gap_ctr", 64'(fft_ctr), 64'(pos));
      end
      @(negedge clk);
      s_valid = 1'b1;
      s_re    = W'($urandom);
      s_im    = W'($urandom);
      s_last  = (bad_at >= 0) ? (pos == bad_at) : (pos == N - 1);
      #1;
      wt = 0;
      while (!s_ready && wt <= 8 * N) begin
        @(negedge clk);
        #1;
        wt++;
      end
      if (!s_ready) begin
        check("ready_timeout", 64'(0), 64'(1));
        s_valid = 1'b0;
        return;
      end
      waits += wt;
      check("acc_ctr", 64'(fft_ctr), 64'(pos));
      check("acc_data", 64'({fft_en, fft_re, fft_im}),
            64'({1'b1, s_re, s_im}));
      exq.push_back('{re: s_re, im: s_im, idx: brev(pos),
                      fst: pos == 0, lst: pos == N - 1});
      pos = (pos + 1) % N;
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 8 * N) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 64'(busy), 64'(0));
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_done(input string tag, input int n0, input int want);
    check(tag, 64'(n_out - n0), 64'(want));
    check("exq_empty", 64'(exq.size()), 64'(0));
  endtask

  initial begin
    int w;
    int n0;
    int e0;
    int c;
    arst = 1'b1;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_re = '0;
    s_im = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_mvalid", 64'(m_valid), 64'(0));
    check("rst_ready", 64'(s_ready), 64'(1));
    check("rst_en", 64'(fft_en), 64'(0));
    check("rst_ctr", 64'(fft_ctr), 64'(0));
    check("rst_err", 64'(err_frame), 64'(0));
    check("rst_mdata", 64'({m_re, m_im, m_idx}), 64'(0));
    @(negedge clk);
    arst = 1'b0;
    repeat (2) @(negedge clk);

    // single frame, then exactly one zero frame
    n0 = n_out;
    idx_log.delete();
    send(N, 0, -1, w);
    c = 0;
    do begin
      @(negedge clk);
      #1;
      c++;
      if (c == 1) begin
        check("t1_flush_rdy", 64'(s_ready), 64'(0));
        check("t1_flush_en", 64'(fft_en), 64'(1));
      end
    end while (busy && c < 4 * N);
    check("t1_busy_len", 64'(c), 64'(N + 1));
    repeat (3) @(negedge clk);
    frame_done("t1_count", n0, N);
    if (idx_log.size() >= 2) begin
      check("t1_idx0", 64'(idx_log[0]), 64'(0));
      check("t1_idx1", 64'(idx_log[1]), 64'(N / 2));
    end else begin
      check("t1_idx_log", 64'(idx_log.size()), 64'(2));
    end

    // three back-to-back frames
    n0 = n_out;
    send(3 * N, 0, -1, w);
    check("t2_no_stall", 64'(w), 64'(0));
    wait_idle();
    frame_done("t2_count", n0, 3 * N);

    // random gaps mid-frame
    n0 = n_out;
    send(2 * N, 50, -1, w);
    wait_idle();
    frame_done("t3_count", n0, 2 * N);

    // new frame arrives while a zero frame is in flight
    n0 = n_out;
    send(N, 0, -1, w);
    repeat (N / 2) @(negedge clk);
    #1;
    check("t4_mid_rdy", 64'(s_ready), 64'(0));
    check("t4_mid_busy", 64'(busy), 64'(1));
    send(N, 0, -1, w);
    check("t4_held", 64'(w >= N / 4 && w <= N), 64'(1));
    wait_idle();
    frame_done("t4_count", n0, 2 * N);

    // early s_last, then missing s_last
    n0 = n_out;
    e0 = n_err;
    send(N, 0, 100, w);
    wait_idle();
    check("t5_err", 64'(n_err - e0), 64'(2));
    frame_done("t5_count", n0, N);

    // reset halfway through output
    n0 = n_out;
    send(N, 0, -1, w);
    c = 0;
    while (n_out - n0 < N / 2 && c < 4 * N) begin
      @(negedge clk);
      c++;
    end
    check("t6_half", 64'(n_out - n0 >= N / 2), 64'(1));
    arst = 1'b1;
    #1;
    check("t6_mvalid", 64'(m_valid), 64'(0));
    check("t6_busy", 64'(busy), 64'(0));
    check("t6_ctr", 64'(fft_ctr), 64'(0));
    exq.delete();
    pos = 0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    n0 = n_out;
    send(N, 0, -1, w);
    wait_idle();
    frame_done("t6_count", n0, N);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
